// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX pipeline register and the execute-stage ALU.
// Also holds the captured-stage record and its bubble value.
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_SUB     = 4'b0110,
    ALU_SLTU    = 4'b0111,
    ALU_ILLEGAL = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_ITYPE = 2'b11
  } alu_op_e;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  store_data;
    logic [3:0]       alu_ctrl;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             illegal;
  } id_ex_t;

  // A bubble is all-zero except the ALU code, which idles as ADD.
  function automatic id_ex_t bubble();
    id_ex_t b;
    b          = '0;
    b.alu_ctrl = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// Combinational ALUOp/funct3/funct7[5] decoder producing the 4-bit ALU code.
// Shared with the multi-cycle execute variant.
module alu_ctrl_dec
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] ALU_Control,
  output logic       illegal
);

  logic [3:0] code;
  logic       bad;

  always_comb begin
    code = ALU_ADD;
    bad  = 1'b0;
    case (ALUOp)
      OP_ADD: code = ALU_ADD;
      OP_SUB: code = ALU_SUB;
      default: begin
        // funct7[5] only distinguishes ADD/SUB in R-type; elsewhere in R-type it is unsupported.
        case (funct3)
          3'b000:  code = (ALUOp == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  code = ALU_AND;
          3'b110:  code = ALU_OR;
          3'b011:  code = ALU_SLTU;
          default: bad  = 1'b1;
        endcase
        if (ALUOp == OP_RTYPE && funct7_5 && funct3 != 3'b000) bad = 1'b1;
      end
    endcase
    ALU_Control = bad ? ALU_ILLEGAL : code;
    illegal     = bad;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands and control, selects ALU B,
// and supports flush (bubble) over stall (hold) over load.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic        ALUSrc,
  input  logic [1:0]  ALUOp,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] ex_store_data,
  output logic [3:0]  ALU_Control,
  output logic [4:0]  ex_rd,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_Branch,
  output logic        ex_illegal
);

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  id_ex_t     stage_q, stage_d, load_val;

  alu_ctrl_dec u_dec (
    .ALUOp       (ALUOp),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .ALU_Control (dec_ctrl),
    .illegal     (dec_illegal)
  );

  always_comb begin
    load_val            = bubble();
    load_val.valid      = 1'b1;
    load_val.pc         = in_pc;
    load_val.a          = rs1_data;
    load_val.b          = ALUSrc ? imm : rs2_data;
    load_val.store_data = rs2_data;
    load_val.alu_ctrl   = dec_ctrl;
    load_val.rd         = rd;
    // Illegal ops stay valid for the trap logic but must not write state.
    load_val.reg_write  = RegWrite & ~dec_illegal;
    load_val.mem_read   = MemRead;
    load_val.mem_write  = MemWrite & ~dec_illegal;
    load_val.branch     = Branch;
    load_val.illegal    = dec_illegal;
  end

  always_comb begin
    stage_d = stage_q;
    if (flush)          stage_d = bubble();
    else if (!stall)    stage_d = in_valid ? load_val : bubble();
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= bubble();
    else        stage_q <= stage_d;
  end

  assign ex_valid      = stage_q.valid;
  assign ex_pc         = stage_q.pc;
  assign A             = stage_q.a;
  assign B             = stage_q.b;
  assign ex_store_data = stage_q.store_data;
  assign ALU_Control   = stage_q.alu_ctrl;
  assign ex_rd         = stage_q.rd;
  assign ex_RegWrite   = stage_q.reg_write;
  assign ex_MemRead    = stage_q.mem_read;
  assign ex_MemWrite   = stage_q.mem_write;
  assign ex_Branch     = stage_q.branch;
  assign ex_illegal    = stage_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a behavioural reference model,
// and a per-cycle comparison of every output against it.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid;
  logic [31:0] in_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rd;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic        funct7_5, RegWrite, MemRead, MemWrite, Branch;
  logic        ex_valid;
  logic [31:0] ex_pc, A, B, ex_store_data;
  logic [3:0]  ALU_Control;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .A(A), .B(B), .ex_store_data(ex_store_data),
    .ALU_Control(ALU_Control), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_illegal(ex_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference decode: returns {illegal, code}.
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    logic [3:0] code;
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) return {1'b0, 4'b0110};
    if (op == 2'b10 && f7 && f3 != 3'b000) return {1'b1, 4'b1111};
    if      (f3 == 3'b000) code = (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
    else if (f3 == 3'b111) code = 4'b0000;
    else if (f3 == 3'b110) code = 4'b0001;
    else if (f3 == 3'b011) code = 4'b0111;
    else return {1'b1, 4'b1111};
    return {1'b0, code};
  endfunction

  logic        m_valid, m_rw, m_mr, m_mw, m_br, m_ill;
  logic [31:0] m_pc, m_a, m_b, m_sd;
  logic [3:0]  m_ctrl;
  logic [4:0]  m_rd;

  task automatic m_bubble();
    {m_valid, m_rw, m_mr, m_mw, m_br, m_ill} = '0;
    {m_pc, m_a, m_b, m_sd} = '0;
    m_rd = '0;
    m_ctrl = 4'b0010;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] d;
    if (!rst_n || flush || (!stall && !in_valid)) m_bubble();
    else if (!stall) begin
      d = ref_decode(ALUOp, funct3, funct7_5);
      m_valid = 1'b1; m_pc = in_pc; m_a = rs1_data;
      m_b = ALUSrc ? imm : rs2_data; m_sd = rs2_data; m_rd = rd;
      m_ctrl = d[3:0]; m_ill = d[4];
      m_rw = RegWrite & ~d[4]; m_mw = MemWrite & ~d[4];
      m_mr = MemRead; m_br = Branch;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) if (cmp_en) begin
    chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    chk("ex_pc", ex_pc, m_pc);
    chk("A", A, m_a);
    chk("B", B, m_b);
    chk("ex_store_data", ex_store_data, m_sd);
    chk("ALU_Control", {28'b0, ALU_Control}, {28'b0, m_ctrl});
    chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
    chk("ctrl_bits", {28'b0, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch},
                     {28'b0, m_rw, m_mr, m_mw, m_br});
    chk("ex_illegal", {31'b0, ex_illegal}, {31'b0, m_ill});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_bubble(input string name);
    chk({name, "_valid"}, {31'b0, ex_valid}, 32'd0);
    chk({name, "_data"}, ex_pc | A | B | ex_store_data, 32'd0);
    chk({name, "_ctrl"}, {28'b0, ALU_Control}, 32'h2);
    chk({name, "_bits"}, {26'b0, ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_illegal}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; stall = 0; flush = 0; in_valid = 0;
    in_pc = 0; rs1_data = 0; rs2_data = 0; imm = 0; rd = 0; ALUSrc = 0;
    ALUOp = 0; funct3 = 0; funct7_5 = 0; RegWrite = 0; MemRead = 0; MemWrite = 0; Branch = 0;
    #1 rst_n = 1'b0;
    #2 chk_bubble("reset");
    tick(); cmp_en = 1;
    rst_n = 1'b1;

    // R-type SUB
    in_valid = 1; in_pc = 32'h100; ALUOp = 2'b10; funct3 = 3'b000; funct7_5 = 1;
    rs1_data = 32'h10; rs2_data = 32'h3; ALUSrc = 0; rd = 5'd7; RegWrite = 1;
    tick();
    chk("sub_A", A, 32'h10);
    chk("sub_B", B, 32'h3);
    chk("sub_ctrl", {28'b0, ALU_Control}, 32'h6);
    chk("sub_valid", {31'b0, ex_valid}, 32'd1);

    // I-type ORI
    in_pc = 32'h104; ALUOp = 2'b11; funct3 = 3'b110; funct7_5 = 0; ALUSrc = 1;
    imm = 32'hFFFF_FFF0; rs2_data = 32'h5; rs1_data = 32'h22; MemRead = 1; Branch = 1;
    tick();
    chk("ori_B", B, 32'hFFFF_FFF0);
    chk("ori_sd", ex_store_data, 32'h5);
    chk("ori_ctrl", {28'b0, ALU_Control}, 32'h1);

    // Stall 3 cycles with changing inputs
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rs1_data = 32'hA000 + i; imm = i; in_pc = 32'h200 + i; ALUOp = 2'b01; in_valid = i[0];
      tick();
    end
    chk("stall_pc", ex_pc, 32'h104);
    chk("stall_A", A, 32'h22);
    chk("stall_B", B, 32'hFFFF_FFF0);
    chk("stall_ctrl", {28'b0, ALU_Control}, 32'h1);

    // Flush beats stall
    in_valid = 1; flush = 1;
    tick();
    chk_bubble("flush");
    flush = 0; stall = 0;

    // Illegal SLT
    ALUOp = 2'b10; funct3 = 3'b010; funct7_5 = 0; RegWrite = 1; MemWrite = 1; MemRead = 0; Branch = 0;
    rs1_data = 32'h1; rs2_data = 32'h2; ALUSrc = 0;
    tick();
    chk("slt_ctrl", {28'b0, ALU_Control}, 32'hF);
    chk("slt_ill", {31'b0, ex_illegal}, 32'd1);
    chk("slt_rw_mw", {30'b0, ex_RegWrite, ex_MemWrite}, 32'd0);
    chk("slt_valid", {31'b0, ex_valid}, 32'd1);

    // Load with in_valid=0 is a bubble
    in_valid = 0; ALUOp = 2'b00;
    tick();
    chk_bubble("invalid");

    // Async reset mid-stall
    in_valid = 1; tick();
    stall = 1; tick();
    #2 rst_n = 0;
    #1 chk_bubble("midstall_rst");
    tick(); rst_n = 1;
    tick();
    chk_bubble("post_rst_stall");
    stall = 0;

    // Decoder sweep
    in_valid = 1; RegWrite = 1; MemWrite = 1; MemRead = 1; Branch = 1;
    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int f7 = 0; f7 < 2; f7++) begin
          ALUOp = op[1:0]; funct3 = f3[2:0]; funct7_5 = f7[0];
          rs1_data = 32'h1000 * op + f3; rs2_data = {24'b0, f3[3:0], f7[3:0]}; imm = ~rs1_data;
          ALUSrc = f3[0]; in_pc = in_pc + 4; rd = rd + 1;
          tick();
        end
    tick();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute in the RV32 core. Captures decoded operands and control, selects the ALU B operand, and converts the 2-bit `ALUOp` plus `funct3`/`funct7[5]` into the 4-bit `ALU_Control` code the execute-stage ALU consumes. Supports stall (hold) and flush (bubble insertion) from the hazard unit, and flags encodings the ALU cannot execute.

## Interface
- No parameters. Data width is fixed at 32 bits and register index width at 5 bits.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold all registered outputs.
- `flush` in 1: load a bubble.
- `in_valid` in 1: the decode-stage instruction is real.
- `in_pc` in 32: PC of the decode-stage instruction.
- `rs1_data`, `rs2_data` in 32 each: register-file read data.
- `imm` in 32: sign-extended immediate.
- `rd` in 5: destination register index.
- `ALUSrc` in 1: 1 selects `imm` for B; 0 selects `rs2_data` for B.
- `ALUOp` in 2: 00 = add, 01 = sub, 10 = R-type decode, 11 = I-type arith decode.
- `funct3` in 3, `funct7_5` in 1: instruction function fields.
- `RegWrite`, `MemRead`, `MemWrite`, `Branch` in 1 each: decode control.
- `ex_valid` out 1: execute-stage instruction is real.
- `ex_pc` out 32: registered PC.
- `A`, `B` out 32: ALU operands.
- `ex_store_data` out 32: registered `rs2_data`.
- `ALU_Control` out 4: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 unsigned less-than, 1111 illegal.
- `ex_rd` out 5: registered destination index.
- `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_Branch` out 1 each: registered control.
- `ex_illegal` out 1: the captured encoding is unsupported.

## Operation
- Each rising edge selects one action, in priority order:
  - `flush` loads a bubble.
  - Otherwise, `stall` holds the current contents.
  - Otherwise, the stage loads the inputs.
- A bubble sets every output to 0, with one exception: `ALU_Control` = 0010 (ADD).
- Load with `in_valid=0` is identical to a bubble.
- Load with `in_valid=1`:
  - Data path: `A`←`rs1_data`; `B`←`ALUSrc ? imm : rs2_data`; `ex_store_data`←`rs2_data`; `ex_pc`, `ex_rd` and the control bits are copied.
  - Decode result: `ALU_Control`←decoded code; `ex_illegal`←decode-illegal.
- Decode rules:
  - `ALUOp` 00 → 0010. `ALUOp` 01 → 0110. For both, `funct3`/`funct7_5` are ignored.
  - `ALUOp` 10, by `funct3`:
    - 000 with `funct7_5`=0 → 0010; 000 with `funct7_5`=1 → 0110.
    - 111 → 0000. 110 → 0001. 011 (SLTU) → 0111.
    - Any other `funct3` is illegal, and so is `funct7_5`=1 with any `funct3` other than 000.
  - `ALUOp` 11, by `funct3` (`funct7_5` ignored): 000 → 0010; 111 → 0000; 110 → 0001; 011 → 0111; any other is illegal.
  - `funct3` 010 (signed SLT/SLTI) is illegal. The ALU provides only an unsigned compare.
- On an illegal decode:
  - `ALU_Control`=1111 and `ex_illegal`=1.
  - `ex_RegWrite`=0 and `ex_MemWrite`=0.
  - `ex_valid` stays 1 so the trap logic sees the instruction.
- Stall holds all outputs bit-exact, including across multiple consecutive cycles.

## Timing
- Latency is 1 cycle, input to output. All outputs are registered and change only on a rising `clk` edge, or on `rst_n` falling.
- `rst_n`=0 forces the bubble state immediately, asynchronously, including mid-stall. The first load occurs on the first rising edge with `rst_n`=1.
- `flush` and `stall` high together: flush wins and the bubble is loaded.
- No handshake back-pressure: the hazard unit owns `stall`, and this block never generates it.

## Structure
- Shared package/include holds:
  - the ALU control codes (AND, OR, ADD, SUB, SLTU, ILLEGAL);
  - the `ALUOp` codes (ADD, SUB, RTYPE, ITYPE).
  - The ALU and this stage both use them.
- Sub-module `alu_ctrl_dec`: combinational decoder, with inputs `ALUOp`, `funct3`, `funct7_5` and outputs `ALU_Control`, `illegal`. It is reused by the future multi-cycle execute variant.
- Top level holds only the register bank, the B mux and the priority logic.

## Test plan
- **Reset:** pulse `rst_n` low between clock edges → all outputs 0 and `ALU_Control`=0010 immediately, with no clock needed.
- **R-type SUB:** `in_valid`=1, `ALUOp`=10, `funct3`=000, `funct7_5`=1, `rs1`=0x10, `rs2`=0x3, `ALUSrc`=0 → next edge `A`=0x10, `B`=0x3, `ALU_Control`=0110, `ex_valid`=1.
- **I-type ORI:** `ALUOp`=11, `funct3`=110, `ALUSrc`=1, `imm`=0xFFFFFFF0, `rs2`=0x5 → `B`=0xFFFFFFF0, `ex_store_data`=0x5, `ALU_Control`=0001.
- **Stall then flush:**
  - Stall for 3 cycles while the inputs change → outputs unchanged.
  - Then `stall`=`flush`=1 → bubble: `ex_valid`=0, `ex_RegWrite`=0.
- **Illegal SLT:** `ALUOp`=10, `funct3`=010, `RegWrite`=1 → `ALU_Control`=1111, `ex_illegal`=1, `ex_RegWrite`=0, `ex_valid`=1.
- **Decoder sweep:** all 4×8×2 `ALUOp`/`funct3`/`funct7_5` combinations → `ALU_Control`/`ex_illegal` match the decode rules exactly.
